// File: rtl/bcd_counter_n.sv
// Cascadable up/down BCD counter of DIGITS digits with clamped parallel load, wrap or saturate, sticky ovf.
// Latency: one clk from load/en to q; cout is combinational from q and controls.
// Backpressure: none; deasserting en holds the count, and cout feeds the en of the next stage.
module bcd_counter_n #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  load,
    input  logic                  en,
    input  logic                  up,
    input  logic [4*DIGITS-1:0]   data,
    output logic [4*DIGITS-1:0]   q,
    output logic                  cout,
    output logic                  ovf
);

    logic [4*DIGITS-1:0] q_step;
    logic [4*DIGITS-1:0] q_load;
    logic                is_full;
    logic                is_zero;
    logic                at_term;
    logic                carry;
    logic [3:0]          d;
    logic [3:0]          ld;

    // Carry/borrow ripples from digit 0 upward within one cycle.
    always_comb begin
        q_step  = q;
        q_load  = '0;
        is_full = 1'b1;
        is_zero = 1'b1;
        carry   = 1'b1;
        d       = '0;
        ld      = '0;
        for (int k = 0; k < DIGITS; k++) begin
            d       = q[4*k +: 4];
            is_full = is_full & (d == 4'd9);
            is_zero = is_zero & (d == 4'd0);
            if (carry) begin
                if (up) begin
                    if (d >= 4'd9) begin
                        q_step[4*k +: 4] = 4'd0;
                    end else begin
                        q_step[4*k +: 4] = d + 4'd1;
                        carry            = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        q_step[4*k +: 4] = 4'd9;
                    end else begin
                        q_step[4*k +: 4] = (d > 4'd9) ? 4'd8 : d - 4'd1;
                        carry            = 1'b0;
                    end
                end
            end
            ld               = data[4*k +: 4];
            q_load[4*k +: 4] = (ld > 4'd9) ? 4'd9 : ld;
        end
        at_term = up ? is_full : is_zero;
    end

    assign cout = en & ~clr & ~load & at_term;

    always_ff @(posedge clk) begin
        if (clr) begin
            q   <= '0;
            ovf <= 1'b0;
        end else if (load) begin
            q <= q_load;
        end else if (en) begin
            if (at_term) begin
                ovf <= 1'b1;
                // Wrapping from a boundary is exactly the rippled step result.
                if (WRAP) begin
                    q <= q_step;
                end
            end else begin
                q <= q_step;
            end
        end
    end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench: 2-digit wrap and saturate counters plus a two-stage 1-digit cascade.
module tb_bcd_counter_n;

    logic       clk;
    logic       clr;
    logic       load;
    logic       en;
    logic       up;
    logic [7:0] data;

    logic [7:0] q_w;
    logic       cout_w;
    logic       ovf_w;
    logic [7:0] q_s;
    logic       cout_s;
    logic       ovf_s;
    logic [3:0] q_c0;
    logic [3:0] q_c1;
    logic       cout_c0;
    logic       cout_c1;
    logic       ovf_c0;
    logic       ovf_c1;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_counter_n #(.DIGITS(2), .WRAP(1'b1)) u_wrap (
        .clk(clk), .clr(clr), .load(load), .en(en), .up(up), .data(data),
        .q(q_w), .cout(cout_w), .ovf(ovf_w)
    );

    bcd_counter_n #(.DIGITS(2), .WRAP(1'b0)) u_sat (
        .clk(clk), .clr(clr), .load(load), .en(en), .up(up), .data(data),
        .q(q_s), .cout(cout_s), .ovf(ovf_s)
    );

    bcd_counter_n #(.DIGITS(1), .WRAP(1'b1)) u_c0 (
        .clk(clk), .clr(clr), .load(load), .en(en), .up(up), .data(data[3:0]),
        .q(q_c0), .cout(cout_c0), .ovf(ovf_c0)
    );

    bcd_counter_n #(.DIGITS(1), .WRAP(1'b1)) u_c1 (
        .clk(clk), .clr(clr), .load(load), .en(cout_c0), .up(up), .data(data[7:4]),
        .q(q_c1), .cout(cout_c1), .ovf(ovf_c1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    initial begin
        clr = 1'b1; load = 1'b1; en = 1'b1; up = 1'b0; data = 8'h55;
        tick(1);
        chk("clr_q_w", 16'(q_w), 16'h00);
        chk("clr_ovf_w", 16'(ovf_w), 16'h0);
        chk("clr_q_s", 16'(q_s), 16'h00);
        chk("clr_ovf_s", 16'(ovf_s), 16'h0);
        #1;
        chk("clr_cout_w", 16'(cout_w), 16'h0);

        clr = 1'b0; load = 1'b0; up = 1'b1; en = 1'b1;
        tick(10);
        chk("up10_q_w", 16'(q_w), 16'h10);
        chk("up10_q_s", 16'(q_s), 16'h10);
        tick(89);
        chk("up99_q_w", 16'(q_w), 16'h99);
        chk("up99_ovf_w", 16'(ovf_w), 16'h0);
        chk("up99_cout_w", 16'(cout_w), 16'h1);
        tick(1);
        chk("wrap_q_w", 16'(q_w), 16'h00);
        chk("wrap_ovf_w", 16'(ovf_w), 16'h1);
        chk("wrap_cout_w", 16'(cout_w), 16'h0);
        chk("sat_q_s", 16'(q_s), 16'h99);
        chk("sat_ovf_s", 16'(ovf_s), 16'h1);
        chk("sat_cout_s", 16'(cout_s), 16'h1);

        data = 8'h3C; load = 1'b1;
        #1;
        chk("load_cout_s", 16'(cout_s), 16'h0);
        tick(1);
        chk("load_q_w", 16'(q_w), 16'h39);
        chk("load_q_s", 16'(q_s), 16'h39);
        chk("load_ovf_w", 16'(ovf_w), 16'h1);

        data = 8'hAF;
        tick(1);
        chk("clamp_q_w", 16'(q_w), 16'h99);

        load = 1'b0; en = 1'b0;
        tick(5);
        chk("hold_q_w", 16'(q_w), 16'h99);
        chk("hold_ovf_w", 16'(ovf_w), 16'h1);

        clr = 1'b1;
        tick(1);
        clr = 1'b0; up = 1'b0; en = 1'b1;
        #1;
        chk("zero_cout_w", 16'(cout_w), 16'h1);
        tick(1);
        chk("down_q_w", 16'(q_w), 16'h99);
        chk("down_ovf_w", 16'(ovf_w), 16'h1);
        chk("down_q_s", 16'(q_s), 16'h00);
        chk("down_ovf_s", 16'(ovf_s), 16'h1);
        tick(1);
        chk("down2_q_w", 16'(q_w), 16'h98);
        chk("down2_q_s", 16'(q_s), 16'h00);

        data = 8'h20; load = 1'b1;
        tick(1);
        chk("ld20_q_w", 16'(q_w), 16'h20);
        load = 1'b0; up = 1'b0;
        tick(1);
        chk("dec_q_w", 16'(q_w), 16'h19);
        up = 1'b1;
        tick(1);
        chk("inc_q_w", 16'(q_w), 16'h20);

        clr = 1'b1;
        tick(1);
        chk("midclr_q_w", 16'(q_w), 16'h00);
        chk("midclr_ovf_w", 16'(ovf_w), 16'h0);

        clr = 1'b0; up = 1'b1; en = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick(1);
            chk("casc_pair", 16'({q_c1, q_c0}), 16'(to_bcd(i % 100)));
            chk("casc_ref", 16'(q_w), 16'(to_bcd(i % 100)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_counter_n.md
BCD_COUNTER_N -- requirements
Module: bcd_counter_n

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4: number of cascaded BCD digits, legal range 1..8.
REQ-002 The block SHALL have parameter WRAP, default 1: 1 = wrap at full/zero scale, 0 = saturate at full/zero scale.
REQ-003 The block SHALL have port clk, input, width 1: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port clr, input, width 1: synchronous, active-high reset/clear.
REQ-005 The block SHALL have port load, input, width 1: parallel load strobe.
REQ-006 The block SHALL have port en, input, width 1: count enable.
REQ-007 The block SHALL have port up, input, width 1: direction; 1 = increment, 0 = decrement.
REQ-008 The block SHALL have port data, input, width 4*DIGITS: load value; digit k occupies bits [4k+3:4k], digit 0 = least significant.
REQ-009 The block SHALL have port q, output, width 4*DIGITS: registered BCD count, same digit packing as data.
REQ-010 The block SHALL have port cout, output, width 1: combinational terminal-count/cascade strobe.
REQ-011 The block SHALL have port ovf, output, width 1: registered sticky wrap/saturate flag.

Function
REQ-012 Per-edge priority SHALL be: clr, then load, then en; with none of these asserted, q and ovf hold.
REQ-013 On load, each data digit of 0..9 SHALL be stored unchanged, and each digit of 10..15 SHALL be stored as 9 (clamp); ovf is unaffected.
REQ-014 On en with up=1, digit 0 SHALL increment; a digit at 9 SHALL go to 0 and carry into the next digit, rippling through all digits within the same cycle.
REQ-015 On en with up=0, digit 0 SHALL decrement; a digit at 0 SHALL go to 9 and borrow from the next digit, rippling within the same cycle.
REQ-016 Full scale is all digits equal to 9; zero is all digits equal to 0.
REQ-017 Up-count at full scale SHALL give q = zero if WRAP=1, and hold q at full scale if WRAP=0.
REQ-018 Down-count at zero SHALL give q = full scale if WRAP=1, and hold q at zero if WRAP=0.
REQ-019 ovf SHALL be set at the edge where REQ-017 or REQ-018 applies, for either WRAP value.
REQ-020 Once set, ovf SHALL remain set until clr.
REQ-021 cout SHALL equal en AND NOT clr AND NOT load AND ((up AND q == full scale) OR (NOT up AND q == zero)); it is purely combinational from the current q and inputs.
REQ-022 cout SHALL be usable as the en of a following bcd_counter_n stage for multi-stage cascade.
REQ-023 q SHALL change only on a clk rising edge: one-cycle latency from load/en to the visible q.
REQ-024 q SHALL never hold a non-BCD digit (digit > 9) under any input sequence.
REQ-025 Toggling up between cycles SHALL take effect on the next enabled edge with no extra delay or state.

Reset
REQ-026 When clr=1 at a rising edge, q SHALL become zero and ovf SHALL become 0, regardless of load, en, up or data.
REQ-027 While clr=1, cout SHALL be 0.
REQ-028 Asserting clr mid-count SHALL take effect at that edge, with no partial digit update retained.
REQ-029 There SHALL be no asynchronous reset path; state before the first clr edge is undefined and is not checked.

Verification (DIGITS=2 unless stated)
REQ-030 Scenario, clear: clr=1 for one edge from any state -> q=0x00, ovf=0, cout=0.
REQ-031 Scenario, up-count wrap: from q=0x00, up=1, en=1 for 10 edges -> q=0x10; continue to q=0x99 -> cout=1; next edge -> q=0x00, ovf=1 (WRAP=1).
REQ-032 Scenario, down-count boundary: q=0x00, up=0, en=1, one edge -> WRAP=1 gives q=0x99, ovf=1; WRAP=0 gives q=0x00, ovf=1, and q stays 0x00 on further edges.
REQ-033 Scenario, load: data=0x3C, load=1 with en=1 -> q=0x39 (clamp; load beats en), cout=0 in that cycle, ovf unchanged.
REQ-034 Scenario, simultaneous controls: clr=1, load=1, data=0x55 -> q=0x00; separately, en=0 for 5 edges -> q holds; from q=0x20, up=0, en=1 -> q=0x19, then up=1 -> q=0x20.
REQ-035 Scenario, cascade: two DIGITS=1 instances, stage-1 en tied to stage-0 cout, counting up from 00 -> the pair tracks a 2-digit BCD count through 99 -> 00, matching the DIGITS=2 q on every edge.
